lenet_result_argmax: RTL and testbench
======================================

# lenet_result_argmax

Downstream classification stage of the LeNet accelerator. It snoops the FC2 write port into SRAM_f and captures the ten signed 8-bit class scores as they are written. On the rising edge of `fc2_done` it performs a sequential argmax over the captured scores. It then presents the winning digit and its score on a valid/ready result interface.

## Interface
Parameters:
- `NUM_CLASS`, 10: number of scores captured and scanned.
- `SCORE_WIDTH`, 8: signed score width; equals the SRAM_f write-data width.
- `WADDR_WIDTH`, 2: SRAM_f write-address width.

Ports:
- `clk` in 1: the single clock.
- `srstn` in 1: asynchronous, active-low reset.
- `sram_write_enable_f` in 1: SRAM_f write strobe, active-low.
- `sram_bytemask_f` in 4: byte-lane mask, active-low. Bit k = 0 selects lane k.
- `sram_waddr_f` in `WADDR_WIDTH`: SRAM_f word address.
- `sram_wdata_f` in `SCORE_WIDTH`: score byte being written.
- `fc2_done` in 1: FC2 completion level; only its rising edge is used.
- `result_valid` out 1: result available.
- `result_ready` in 1: consumer accepts the result.
- `result_class` out 4: winning class 0..9, or 4'hF on error.
- `result_score` out `SCORE_WIDTH`: winning score, signed.
- `result_error` out 1: result produced with missing scores.
- `busy` out 1: high in SCAN and HOLD.
- `overrun` out 1: sticky flag; set when a write was dropped. Cleared only by reset.

## Operation
- Score mapping: index = `sram_waddr_f`*4 + k for every lane k with `sram_bytemask_f[k]`==0, when `sram_write_enable_f`==0.
  - Several lanes may be selected in one write; each selected lane gets `sram_wdata_f`.
  - Indices ≥ `NUM_CLASS` (addr 2, lanes 2–3; addr 3) are ignored without error.
- Capture state keeps a `NUM_CLASS`-bit written mask alongside the score registers.
  - Rewriting an index overwrites the score (last write wins).
- States:
  - **CAPTURE** (reset state): accepts writes. A rising edge of `fc2_done` moves to SCAN. A write in the same cycle as the edge is captured first and then used in the scan.
  - **SCAN**: one index per cycle, 0..`NUM_CLASS`-1.
    - best ← index 0, then updated only when score[i] > best, as a strict signed compare. Ties therefore resolve to the lowest index.
    - After index `NUM_CLASS`-1, go to HOLD.
    - If the mask is not all-ones, the result is class 4'hF, score 0, and `result_error`=1.
  - **HOLD**: `result_valid`=1. The class, score and error outputs are stable until the handshake. On `result_valid` && `result_ready`, clear the mask and go to CAPTURE.
- Writes arriving in SCAN or HOLD are dropped and set `overrun`.
- Rising edges of `fc2_done` outside CAPTURE are ignored.
- Edge detection uses a registered copy of `fc2_done`, reset to 0. A `fc2_done` already high when leaving reset is therefore seen as an edge.

## Timing
- Reset values:
  - `result_valid`=0, `result_class`=0, `result_score`=0, `result_error`=0.
  - `busy`=0, `overrun`=0.
  - Mask is all-zero; scores are 0; `fc2_done` delay register is 0.
- Latency: `fc2_done` rises at edge T, so SCAN covers cycles T+1..T+`NUM_CLASS`. `result_valid` goes high at T+`NUM_CLASS`+1 (T+11 by default).
- `result_ready` may be high before `result_valid`. In that case the handshake completes in the first HOLD cycle and CAPTURE resumes on the next cycle, so the minimum HOLD is 1 cycle.
- A write in the handshake cycle is dropped, because the block is still in HOLD.
- Reset asserted mid-SCAN or mid-HOLD returns to CAPTURE immediately. The result is discarded.
- All outputs are registered; there is no combinational path from input to output.

## Structure
- Shared package `lenet_pkg`: `NUM_CLASS`, `SCORE_WIDTH`, the `CLASS_ERR`=4'hF constant, and the state enum {CAPTURE, SCAN, HOLD}.
- One sub-module, `score_capture_regfile`. It decodes the write port into the score registers and the mask, and provides an indexed read port for the scan.
- The FSM, scan counter, comparator and result registers live in the top.

## Test plan
- Write scores {3,-5,7,7,0,-128,127,1,2,0} over addrs 0–2 with single-lane masks, then pulse `fc2_done`, holding `result_ready`=1 → `result_valid` at T+11, class 6, score 127, error 0.
- Scores with a tie at max 7 on indices 2 and 3 (all others negative) → class 2, score 7.
- Write all 10 scores as -1 except index 9, which is never written; pulse `fc2_done` → class 4'hF, score 0, `result_error`=1.
- Write at addr 1 with mask 4'b0000 and data 9 → indices 4–7 all get 9. Write addr 2 with mask 4'b0011 and data 50 → nothing is stored in indices 10–11, error stays 0.
- Hold `result_ready`=0 for 20 cycles and issue a write during HOLD → outputs stay stable, `overrun`=1. Then `result_ready`=1 → CAPTURE, with the mask cleared.
- Assert `srstn`=0 at T+5 during SCAN → all outputs return to reset values. A fresh capture and scan then completes normally.

Source files
------------

// File: rtl/lenet_pkg.sv
// Shared constants and state encoding for the LeNet result-argmax stage.
package lenet_pkg;
    localparam int         NUM_CLASS   = 10;
    localparam int         SCORE_WIDTH = 8;
    localparam logic [3:0] CLASS_ERR   = 4'hF;

    typedef enum logic [1:0] {CAPTURE, SCAN, HOLD} state_e;
endpackage

// File: rtl/score_capture_regfile.sv
// Snooped FC2 score registers with a written-mask and an indexed read port for the scan.
module score_capture_regfile
    import lenet_pkg::*;
#(
    parameter int NUM_CLASS   = lenet_pkg::NUM_CLASS,
    parameter int SCORE_WIDTH = lenet_pkg::SCORE_WIDTH,
    parameter int WADDR_WIDTH = 2
) (
    input  logic                          clk,
    input  logic                          srstn,
    input  logic                          wr_en,
    input  logic [3:0]                    bytemask,
    input  logic [WADDR_WIDTH-1:0]        waddr,
    input  logic [SCORE_WIDTH-1:0]        wdata,
    input  logic                          clr_mask,
    input  logic [3:0]                    rd_idx,
    output logic signed [SCORE_WIDTH-1:0] rd_score,
    output logic                          mask_full
);
    logic [NUM_CLASS-1:0][SCORE_WIDTH-1:0] score_q, score_d;
    logic [NUM_CLASS-1:0]                  mask_q, mask_d;

    // Each index owns a fixed (address, lane) pair; indices past NUM_CLASS simply have no register.
    for (genvar i = 0; i < NUM_CLASS; i++) begin : g_idx
        localparam int                     LANE = i % 4;
        localparam logic [WADDR_WIDTH-1:0] ADDR = WADDR_WIDTH'(i / 4);
        logic hit;
        assign hit       = wr_en && !bytemask[LANE] && (waddr == ADDR);
        assign score_d[i] = hit ? wdata : score_q[i];
        assign mask_d[i]  = hit | (mask_q[i] & ~clr_mask);
    end

    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            score_q <= '0;
            mask_q  <= '0;
        end else begin
            score_q <= score_d;
            mask_q  <= mask_d;
        end
    end

    assign rd_score  = (rd_idx < 4'(NUM_CLASS)) ? score_q[rd_idx] : '0;
    assign mask_full = &mask_q;
endmodule

// File: rtl/lenet_result_argmax.sv
// Captures FC2 class scores off the SRAM_f write port and reports the argmax on a valid/ready port.
module lenet_result_argmax
    import lenet_pkg::*;
#(
    parameter int NUM_CLASS   = lenet_pkg::NUM_CLASS,
    parameter int SCORE_WIDTH = lenet_pkg::SCORE_WIDTH,
    parameter int WADDR_WIDTH = 2
) (
    input  logic                          clk,
    input  logic                          srstn,
    input  logic                          sram_write_enable_f,
    input  logic [3:0]                    sram_bytemask_f,
    input  logic [WADDR_WIDTH-1:0]        sram_waddr_f,
    input  logic [SCORE_WIDTH-1:0]        sram_wdata_f,
    input  logic                          fc2_done,
    output logic                          result_valid,
    input  logic                          result_ready,
    output logic [3:0]                    result_class,
    output logic signed [SCORE_WIDTH-1:0] result_score,
    output logic                          result_error,
    output logic                          busy,
    output logic                          overrun
);
    localparam logic [3:0] LAST_IDX = 4'(NUM_CLASS - 1);

    state_e                        state_q, state_d;
    logic                          fc2_q;
    logic [3:0]                    idx_q, idx_d;
    logic signed [SCORE_WIDTH-1:0] best_q, best_d;
    logic [3:0]                    best_idx_q, best_idx_d;
    logic                          valid_q, valid_d;
    logic [3:0]                    class_q, class_d;
    logic signed [SCORE_WIDTH-1:0] score_q, score_d;
    logic                          error_q, error_d;
    logic                          busy_q, busy_d;
    logic                          overrun_q, overrun_d;

    logic                          wr_req, cap_wr, fc2_rise, clr_mask, mask_full;
    logic signed [SCORE_WIDTH-1:0] rd_score;

    assign wr_req   = !sram_write_enable_f && (sram_bytemask_f != 4'hF);
    assign cap_wr   = wr_req && (state_q == CAPTURE);
    assign fc2_rise = fc2_done && !fc2_q;

    score_capture_regfile #(
        .NUM_CLASS  (NUM_CLASS),
        .SCORE_WIDTH(SCORE_WIDTH),
        .WADDR_WIDTH(WADDR_WIDTH)
    ) u_regfile (
        .clk      (clk),
        .srstn    (srstn),
        .wr_en    (cap_wr),
        .bytemask (sram_bytemask_f),
        .waddr    (sram_waddr_f),
        .wdata    (sram_wdata_f),
        .clr_mask (clr_mask),
        .rd_idx   (idx_q),
        .rd_score (rd_score),
        .mask_full(mask_full)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        best_d     = best_q;
        best_idx_d = best_idx_q;
        valid_d    = valid_q;
        class_d    = class_q;
        score_d    = score_q;
        error_d    = error_q;
        clr_mask   = 1'b0;
        overrun_d  = overrun_q | (wr_req && (state_q != CAPTURE));
        case (state_q)
            CAPTURE: begin
                if (fc2_rise) begin
                    state_d = SCAN;
                    idx_d   = '0;
                end
            end
            SCAN: begin
                // Strict compare keeps the lowest index on ties.
                if ((idx_q == '0) || (rd_score > best_q)) begin
                    best_d     = rd_score;
                    best_idx_d = idx_q;
                end
                idx_d = idx_q + 4'd1;
                if (idx_q == LAST_IDX) begin
                    state_d = HOLD;
                    valid_d = 1'b1;
                    if (mask_full) begin
                        class_d = best_idx_d;
                        score_d = best_d;
                        error_d = 1'b0;
                    end else begin
                        class_d = CLASS_ERR;
                        score_d = '0;
                        error_d = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (result_ready) begin
                    state_d  = CAPTURE;
                    valid_d  = 1'b0;
                    clr_mask = 1'b1;
                end
            end
            default: state_d = CAPTURE;
        endcase
        busy_d = (state_d != CAPTURE);
    end

    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            state_q    <= CAPTURE;
            fc2_q      <= 1'b0;
            idx_q      <= '0;
            best_q     <= '0;
            best_idx_q <= '0;
            valid_q    <= 1'b0;
            class_q    <= '0;
            score_q    <= '0;
            error_q    <= 1'b0;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            fc2_q      <= fc2_done;
            idx_q      <= idx_d;
            best_q     <= best_d;
            best_idx_q <= best_idx_d;
            valid_q    <= valid_d;
            class_q    <= class_d;
            score_q    <= score_d;
            error_q    <= error_d;
            busy_q     <= busy_d;
            overrun_q  <= overrun_d;
        end
    end

    assign result_valid = valid_q;
    assign result_class = class_q;
    assign result_score = score_q;
    assign result_error = error_q;
    assign busy         = busy_q;
    assign overrun      = overrun_q;
endmodule

// File: tb/tb_lenet_result_argmax.sv
// Scoreboard bench for lenet_result_argmax: model predicts each result when fc2_done is pulsed.
module tb_lenet_result_argmax;
    logic       clk = 1'b0, srstn = 1'b0;
    logic       we_n = 1'b1;
    logic [3:0] bm = 4'hF;
    logic [1:0] wa = 2'd0;
    logic [7:0] wd = 8'd0;
    logic       fc2 = 1'b0, rr = 1'b0;
    logic       rv, re, busy, ovr;
    logic [3:0] rc;
    logic [7:0] rs;

    typedef struct {
        logic [3:0] cls;
        logic [7:0] sc;
        logic       err;
    } exp_t;

    exp_t             sb[$];
    exp_t             last_e;
    logic signed [7:0] m_sc[10];
    logic [9:0]        m_mk = '0;
    int checks = 0, failures = 0;

    lenet_result_argmax dut (
        .clk                (clk),
        .srstn              (srstn),
        .sram_write_enable_f(we_n),
        .sram_bytemask_f    (bm),
        .sram_waddr_f       (wa),
        .sram_wdata_f       (wd),
        .fc2_done           (fc2),
        .result_valid       (rv),
        .result_ready       (rr),
        .result_class       (rc),
        .result_score       (rs),
        .result_error       (re),
        .busy               (busy),
        .overrun            (ovr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void mdl_wr(input logic [1:0] a, input logic [3:0] m, input logic [7:0] d);
        for (int k = 0; k < 4; k++) begin
            int idx = int'(a) * 4 + k;
            if (!m[k] && idx < 10) begin
                m_sc[idx] = d;
                m_mk[idx] = 1'b1;
            end
        end
    endfunction

    function automatic exp_t mdl_exp();
        exp_t e;
        logic signed [7:0] best = m_sc[0];
        int bi = 0;
        for (int i = 1; i < 10; i++)
            if (m_sc[i] > best) begin
                best = m_sc[i];
                bi   = i;
            end
        if (m_mk != 10'h3FF) begin
            e.cls = 4'hF; e.sc = 8'd0; e.err = 1'b1;
        end else begin
            e.cls = 4'(bi); e.sc = best; e.err = 1'b0;
        end
        return e;
    endfunction

    task automatic wr(input logic [1:0] a, input logic [3:0] m, input logic [7:0] d);
        we_n = 1'b0; wa = a; bm = m; wd = d;
        tick();
        we_n = 1'b1; bm = 4'hF;
        mdl_wr(a, m, d);
    endtask

    task automatic wr_idx(input int i, input int v);
        wr(2'(i / 4), ~(4'b0001 << (i % 4)), 8'(v));
    endtask

    // Optionally writes in the same cycle as the fc2_done edge.
    task automatic run_scan(input bit do_wr, input logic [1:0] a, input logic [3:0] m,
                            input logic [7:0] d);
        int   n;
        exp_t e;
        if (do_wr) begin
            we_n = 1'b0; wa = a; bm = m; wd = d;
            mdl_wr(a, m, d);
        end
        sb.push_back(mdl_exp());
        fc2 = 1'b1;
        tick();
        we_n = 1'b1; bm = 4'hF; fc2 = 1'b0;
        chk("busy_scan", 32'(busy), 32'd1);
        n = 1;
        while (!rv && n < 40) begin
            tick();
            n++;
        end
        chk("latency", 32'(n), 32'd11);
        e      = sb.pop_front();
        last_e = e;
        chk("class", 32'(rc), 32'(e.cls));
        chk("score", 32'(rs), 32'(e.sc));
        chk("error", 32'(re), 32'(e.err));
        if (rr) begin
            tick();
            chk("valid_clr", 32'(rv), 32'd0);
            chk("busy_clr", 32'(busy), 32'd0);
            m_mk = '0;
        end
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_valid"}, 32'(rv), 32'd0);
        chk({tag, "_class"}, 32'(rc), 32'd0);
        chk({tag, "_score"}, 32'(rs), 32'd0);
        chk({tag, "_error"}, 32'(re), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_ovr"}, 32'(ovr), 32'd0);
    endtask

    initial begin
        int s1[10] = '{3, -5, 7, 7, 0, -128, 127, 1, 2, 0};
        int s2[10] = '{-1, -2, 7, 7, -3, -4, -5, -6, -7, -8};
        for (int i = 0; i < 10; i++) m_sc[i] = 8'sd0;

        repeat (3) tick();
        chk_reset_outs("rst");
        srstn = 1'b1;
        tick();

        // Distinct scores, ready held high throughout
        rr = 1'b1;
        for (int i = 0; i < 10; i++) wr_idx(i, s1[i]);
        run_scan(1'b0, 2'd0, 4'hF, 8'd0);

        // Tie at the maximum resolves to lowest index
        for (int i = 0; i < 10; i++) wr_idx(i, s2[i]);
        run_scan(1'b0, 2'd0, 4'hF, 8'd0);

        // Index 9 never written
        for (int i = 0; i < 9; i++) wr_idx(i, -1);
        run_scan(1'b0, 2'd0, 4'hF, 8'd0);

        // Multi-lane writes; indices 10..11 and address 3 fall outside the score file
        wr(2'd0, 4'b0000, 8'hFD);
        wr(2'd1, 4'b0000, 8'd9);
        wr(2'd2, 4'b1100, 8'hF9);
        wr(2'd2, 4'b0011, 8'd50);
        wr(2'd3, 4'b0000, 8'd60);
        run_scan(1'b0, 2'd0, 4'hF, 8'd0);

        // Long HOLD with a dropped write
        rr = 1'b0;
        for (int i = 0; i < 10; i++) wr_idx(i, i * 13 - 60);
        run_scan(1'b0, 2'd0, 4'hF, 8'd0);
        for (int c = 0; c < 20; c++) begin
            if (c == 5) begin
                we_n = 1'b0; wa = 2'd0; bm = 4'b1110; wd = 8'd100;
            end
            tick();
            we_n = 1'b1; bm = 4'hF;
            chk("hold_valid", 32'(rv), 32'd1);
            chk("hold_class", 32'(rc), 32'(last_e.cls));
            chk("hold_score", 32'(rs), 32'(last_e.sc));
        end
        chk("overrun_set", 32'(ovr), 32'd1);
        rr = 1'b1;
        tick();
        chk("hs_valid", 32'(rv), 32'd0);
        chk("hs_busy", 32'(busy), 32'd0);
        m_mk = '0;
        // Mask must be clear after the handshake, so an empty capture errors out
        run_scan(1'b0, 2'd0, 4'hF, 8'd0);
        chk("overrun_sticky", 32'(ovr), 32'd1);

        // Reset in the middle of a scan
        for (int i = 0; i < 10; i++) wr_idx(i, 5);
        fc2 = 1'b1;
        tick();
        fc2 = 1'b0;
        repeat (4) tick();
        srstn = 1'b0;
        #1;
        chk_reset_outs("midrst");
        m_mk = '0;
        for (int i = 0; i < 10; i++) m_sc[i] = 8'sd0;
        tick();
        srstn = 1'b1;
        tick();
        for (int i = 0; i < 9; i++) wr_idx(i, -10 * (i + 1));
        // Index 9 written in the same cycle as the fc2_done edge
        run_scan(1'b1, 2'd2, 4'b1101, 8'd100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
